// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants and types for the two-port SRAM arbiter.
package sram_port_arbiter_pkg;
  localparam int ADDR_W_DEF   = 12;
  localparam int DATA_W_DEF   = 16;
  localparam int MAX_HOLD_DEF = 16;
  localparam int NUM_PORTS    = 2;
  localparam int RD_LAT       = 2;

  typedef enum logic {ST_FREE = 1'b0, ST_LOCKED = 1'b1} arb_st_e;

  localparam logic PORT_LOAD  = 1'b0;
  localparam logic PORT_PARSE = 1'b1;
endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side bus of the arbiter: both ports' request and response signals.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              lock0, lock1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
  );
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
  );
endinterface

// File: rtl/sram_port_arbiter_rd_pipe.sv
// Read-return tracker: carries {valid, port} alongside the SRAM read latency
// and steers DO to the port that issued the read.
module sram_rd_pipe
  import sram_port_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              issue_vld,
  input  logic                              issue_port,
  input  logic [DATA_W-1:0]                 mem_dout,
  output logic [NUM_PORTS-1:0]              rvalid,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]  rdata,
  output logic                              inflight
);
  logic [RD_LAT:1] vld_pipe;
  logic [RD_LAT:1] port_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      port_pipe <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[RD_LAT-1:1], issue_vld};
      port_pipe <= {port_pipe[RD_LAT-1:1], issue_port};
    end
  end

  assign inflight = |vld_pipe;

  // Outputs are forced quiet while reset is held, not just after it.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign rvalid[p] = ~rst & vld_pipe[RD_LAT] & (port_pipe[RD_LAT] == 1'(p));
    assign rdata[p]  = rvalid[p] ? mem_dout : '0;
  end
endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter with burst lock and starvation bound in front of a
// single-port SRAM; drives registered A/DI/WEB and routes read returns.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic               clk,
  input  logic               rst,
  sram_port_arbiter_if.slave bus,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_din,
  output logic               mem_we_b,
  input  logic [DATA_W-1:0]  mem_dout,
  output logic               busy
);
  localparam int HW = $clog2(MAX_HOLD + 1);

  arb_st_e         st_q, st_d;
  logic            owner_q, owner_d;
  logic            rr_q, rr_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [1:0]      req, lock, gnt;
  logic            own_req, oth_req, own_lock, acc, sel_we;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic            we_b_q, inflight;
  logic [NUM_PORTS-1:0]             rvalid;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdata;

  assign req  = {bus.req1, bus.req0};
  assign lock = {bus.lock1, bus.lock0};

  always_comb begin
    st_d     = st_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    hold_d   = hold_q;
    gnt      = 2'b00;
    own_req  = owner_q ? req[1]  : req[0];
    oth_req  = owner_q ? req[0]  : req[1];
    own_lock = owner_q ? lock[1] : lock[0];
    case (st_q)
      ST_FREE: begin
        if (req == 2'b11) begin
          gnt  = rr_q ? 2'b10 : 2'b01;
          rr_d = ~rr_q;
        end else begin
          gnt = req;
        end
        if (|(gnt & lock)) begin
          st_d    = ST_LOCKED;
          owner_d = gnt[1] ? PORT_PARSE : PORT_LOAD;
          hold_d  = HW'(1);
        end
      end
      ST_LOCKED: begin
        if (!own_req) begin
          st_d   = ST_FREE;
          hold_d = '0;
        end else if (oth_req && hold_q == HW'(MAX_HOLD)) begin
          // Starvation bound hit: hand one access to the waiting port.
          gnt    = owner_q ? 2'b01 : 2'b10;
          st_d   = ST_FREE;
          rr_d   = owner_q;
          hold_d = '0;
        end else begin
          gnt = owner_q ? 2'b10 : 2'b01;
          if (!own_lock) begin
            st_d   = ST_FREE;
            hold_d = '0;
          end else if (hold_q != HW'(MAX_HOLD)) begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      default: st_d = ST_FREE;
    endcase
    if (rst) gnt = 2'b00;
  end

  assign acc    = |gnt;
  assign sel_we = gnt[1] ? bus.we1 : bus.we0;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= ST_FREE;
      owner_q <= PORT_LOAD;
      rr_q    <= PORT_LOAD;
      hold_q  <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      we_b_q  <= 1'b1;
    end else begin
      st_q    <= st_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      if (acc) begin
        addr_q <= gnt[1] ? bus.addr1  : bus.addr0;
        din_q  <= gnt[1] ? bus.wdata1 : bus.wdata0;
        we_b_q <= ~sel_we;
      end else begin
        we_b_q <= 1'b1;
      end
    end
  end

  // Gating with rst kills a write that was already on the pins at the reset edge.
  assign mem_addr = rst ? '0 : addr_q;
  assign mem_din  = rst ? '0 : din_q;
  assign mem_we_b = we_b_q | rst;

  sram_rd_pipe #(.DATA_W(DATA_W)) u_rd_pipe (
    .clk        (clk),
    .rst        (rst),
    .issue_vld  (acc & ~sel_we),
    .issue_port (gnt[1]),
    .mem_dout   (mem_dout),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .inflight   (inflight)
  );

  assign bus.gnt0    = gnt[0];
  assign bus.gnt1    = gnt[1];
  assign bus.rvalid0 = rvalid[0];
  assign bus.rvalid1 = rvalid[1];
  assign bus.rdata0  = rdata[0];
  assign bus.rdata1  = rdata[1];
  assign busy        = ~rst & ((|req) | inflight);
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized + directed bench for sram_port_arbiter against a transaction-level model.
module tb_sram_port_arbiter;
  import sram_port_arbiter_pkg::*;
  localparam int AW = 12, DW = 16, MH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic          mem_we_b, busy;

  sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_we_b(mem_we_b), .mem_dout(mem_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  // SRAM macro: registered DO on reads, writes when WEB low.
  logic [DW-1:0] sram [0:4095];
  always @(posedge clk) begin
    if (!mem_we_b) sram[mem_addr] <= mem_din;
    else           mem_dout <= sram[mem_addr];
  end

  typedef struct packed {
    logic req, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic lock;
  } preq_t;

  typedef struct { int due; bit port; logic [DW-1:0] data; } rd_t;

  // Model state
  bit            m_lk, m_own, m_rr;
  int            m_hold;
  logic [DW-1:0] shadow [0:4095];
  bit            pw_v;
  logic [AW-1:0] pw_a;
  logic [DW-1:0] pw_d;
  bit            e_we_b;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din;
  rd_t           rq[$];
  int            cyc, total, bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic preq_t mk(bit req, bit we, logic [AW-1:0] a, logic [DW-1:0] d, bit lk);
    preq_t p;
    p.req = req; p.we = we; p.addr = a; p.wdata = d; p.lock = lk;
    return p;
  endfunction

  function automatic preq_t rnd(int pct_req, int pct_lock);
    logic [AW-1:0] a;
    a = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'(12'hFFF - $urandom_range(0, 3));
    return mk($urandom_range(0, 99) < pct_req, $urandom_range(0, 99) < 40, a,
              DW'($urandom), $urandom_range(0, 99) < pct_lock);
  endfunction

  // One clock cycle: apply inputs, check everything against the model, advance.
  task automatic step(input bit r, input preq_t p0, input preq_t p1);
    bit [1:0] g;
    bit own_r, oth_r, starve, ev0, ev1, bexp;
    logic [DW-1:0] ed0, ed1;
    preq_t pg;
    rst = r;
    bus.req0 = p0.req; bus.we0 = p0.we; bus.addr0 = p0.addr; bus.wdata0 = p0.wdata; bus.lock0 = p0.lock;
    bus.req1 = p1.req; bus.we1 = p1.we; bus.addr1 = p1.addr; bus.wdata1 = p1.wdata; bus.lock1 = p1.lock;
    #1;
    chk("pins", {mem_we_b, mem_addr, mem_din},
        r ? {1'b1, AW'(0), DW'(0)} : {e_we_b, e_addr, e_din});
    bexp = !r && (p0.req || p1.req || rq.size() > 0);
    chk("busy", 64'(busy), 64'(bexp));
    ev0 = 0; ev1 = 0; ed0 = '0; ed1 = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      if (!r) begin
        if (rq[0].port) begin ev1 = 1; ed1 = rq[0].data; end
        else            begin ev0 = 1; ed0 = rq[0].data; end
      end
      void'(rq.pop_front());
    end
    chk("rd0", {bus.rvalid0, bus.rdata0}, {ev0, ed0});
    chk("rd1", {bus.rvalid1, bus.rdata1}, {ev1, ed1});

    g = 2'b00; own_r = 0; oth_r = 0; starve = 0;
    if (!r) begin
      if (!m_lk) begin
        if (p0.req && p1.req) g = m_rr ? 2'b10 : 2'b01;
        else                  g = {p1.req, p0.req};
      end else begin
        own_r  = m_own ? p1.req : p0.req;
        oth_r  = m_own ? p0.req : p1.req;
        starve = own_r && oth_r && m_hold == MH;
        if (starve)     g = m_own ? 2'b01 : 2'b10;
        else if (own_r) g = m_own ? 2'b10 : 2'b01;
      end
    end
    chk("gnt", 64'({bus.gnt1, bus.gnt0}), 64'(g));

    if (pw_v && !r) shadow[pw_a] = pw_d;
    pw_v = 0;
    if (r) begin
      rq.delete();
      m_lk = 0; m_rr = 0; m_hold = 0;
      e_we_b = 1; e_addr = '0; e_din = '0;
    end else begin
      pg = g[1] ? p1 : p0;
      if (g != 0) begin
        e_addr = pg.addr; e_din = pg.wdata; e_we_b = !pg.we;
        if (pg.we) begin pw_v = 1; pw_a = pg.addr; pw_d = pg.wdata; end
        else rq.push_back('{cyc + 2, g[1], shadow[pg.addr]});
      end else begin
        e_we_b = 1;
      end
      if (!m_lk) begin
        if (p0.req && p1.req) m_rr = !m_rr;
        if (g != 0 && pg.lock) begin m_lk = 1; m_own = g[1]; m_hold = 1; end
      end else if (!own_r) begin
        m_lk = 0;
      end else if (starve) begin
        m_lk = 0; m_rr = m_own;
      end else if (pg.lock) begin
        if (m_hold < MH) m_hold++;
      end else begin
        m_lk = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  preq_t idle;
  int mode;

  initial begin
    for (int i = 0; i < 4096; i++) begin sram[i] = '0; shadow[i] = '0; end
    idle = mk(0, 0, '0, '0, 0);
    total = 0; bad = 0; cyc = 0; pw_v = 0;
    m_lk = 0; m_own = 0; m_rr = 0; m_hold = 0;
    e_we_b = 1; e_addr = '0; e_din = '0;

    step(1, idle, idle);
    step(1, idle, idle);
    // Single port: write 0..3 then read them back.
    for (int i = 0; i < 4; i++) step(0, mk(1, 1, AW'(i), DW'(16'h1111 * (i + 1)), 0), idle);
    for (int i = 0; i < 4; i++) step(0, mk(1, 0, AW'(i), '0, 0), idle);
    for (int i = 0; i < 3; i++) step(0, idle, idle);
    // Contention from reset: alternating grants.
    step(1, idle, idle);
    for (int i = 0; i < 6; i++) step(0, mk(1, 0, AW'(i), '0, 0), mk(1, 0, AW'(i + 8), '0, 0));
    for (int i = 0; i < 3; i++) step(0, idle, idle);
    // Lock with starvation bound.
    step(1, idle, idle);
    for (int i = 0; i < 20; i++) step(0, mk(1, 0, AW'(i & 3), '0, 1), mk(1, 0, AW'(5), '0, 0));
    for (int i = 0; i < 3; i++) step(0, idle, idle);
    // Lock release by dropping req for one cycle.
    step(1, idle, idle);
    for (int i = 0; i < 3; i++) step(0, mk(1, 0, AW'(1), '0, 1), mk(1, 0, AW'(2), '0, 0));
    step(0, idle, mk(1, 0, AW'(2), '0, 0));
    for (int i = 0; i < 2; i++) step(0, idle, mk(1, 0, AW'(3), '0, 0));
    // Read-after-write across ports.
    step(0, mk(1, 1, 12'hFFF, 16'hABCD, 0), idle);
    step(0, idle, mk(1, 0, 12'hFFF, '0, 0));
    for (int i = 0; i < 3; i++) step(0, idle, idle);
    // Reset while a read and a write are in flight.
    step(0, mk(1, 1, 12'h004, 16'h5A5A, 0), idle);
    step(0, mk(1, 0, AW'(2), '0, 0), idle);
    step(1, mk(1, 1, AW'(7), 16'h7777, 1), mk(1, 0, AW'(3), '0, 0));
    for (int i = 0; i < 3; i++) step(0, idle, idle);
    step(0, mk(1, 0, 12'h004, '0, 0), idle);
    for (int i = 0; i < 3; i++) step(0, idle, idle);

    // Randomized traffic in bursts of differing density.
    mode = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 32 == 0) mode = $urandom_range(0, 2);
      case (mode)
        0:       step($urandom_range(0, 199) == 0, rnd(70, 50), rnd(70, 50));
        1:       step($urandom_range(0, 199) == 0, rnd(100, 90), rnd(100, 30));
        default: step($urandom_range(0, 199) == 0, rnd(25, 30), rnd(25, 30));
      endcase
    end
    for (int i = 0; i < 3; i++) step(0, idle, idle);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
